// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use / memory-wait stall sequencing and registered EX forwarding selects
// for a 5-stage pipeline, driven by destination tags of in-flight instructions.
module hazard_stall_controller #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rA_address,
   input  logic [REG_ADDR_W-1:0] id_rB_address,
   input  logic                  id_rA_used,
   input  logic                  id_rB_used,
   input  logic [REG_ADDR_W-1:0] id_rD_address,
   input  logic                  id_wr_en,
   input  logic                  id_is_load,
   input  logic                  id_is_store,
   input  logic                  mem_req_done,
   output logic                  stall_front,
   output logic                  bubble_ex,
   output logic                  freeze_pipe,
   output logic [1:0]            fwd_rA_sel,
   output logic [1:0]            fwd_rB_sel,
   output logic [CNT_W-1:0]      stall_count
);
   localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, LOAD_USE = 2'd2;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  wr;
      logic                  ld;
      logic                  mem_op;
   } tag_t;
   tag_t ex_q, mem_q, id_tag;
   logic [1:0] state_q, state_d, sel_a_q, sel_b_q, sel_a_d, sel_b_d;
   logic [CNT_W-1:0] cnt_q;
   logic m_ex_a, m_ex_b, m_mem_a, m_mem_b, load_use;
   assign m_ex_a  = id_valid & id_rA_used & ex_q.wr  & (id_rA_address == ex_q.rd);
   assign m_ex_b  = id_valid & id_rB_used & ex_q.wr  & (id_rB_address == ex_q.rd);
   assign m_mem_a = id_valid & id_rA_used & mem_q.wr & (id_rA_address == mem_q.rd);
   assign m_mem_b = id_valid & id_rB_used & mem_q.wr & (id_rB_address == mem_q.rd);
   assign freeze_pipe = mem_q.mem_op & ~mem_req_done;
   assign load_use    = ex_q.ld & (m_ex_a | m_ex_b);
   assign stall_front = freeze_pipe | load_use;
   assign bubble_ex   = load_use & ~freeze_pipe;
   assign fwd_rA_sel  = sel_a_q;
   assign fwd_rB_sel  = sel_b_q;
   assign stall_count = cnt_q;
   always_comb begin
      id_tag  = id_valid ? {id_rD_address, (id_wr_en & ~id_is_store) | id_is_load, id_is_load,
                            id_is_load | id_is_store} : '0;
      // a load in EX never forwards from EX/MEM; load-use bubbles it into MEM first
      sel_a_d = (m_ex_a & ~ex_q.ld) ? 2'b01 : m_mem_a ? 2'b10 : 2'b00;
      sel_b_d = (m_ex_b & ~ex_q.ld) ? 2'b01 : m_mem_b ? 2'b10 : 2'b00;
      state_d = (state_q == MEM_WAIT) ? (mem_req_done ? RUN : MEM_WAIT) :
                (state_q == LOAD_USE) ? (freeze_pipe ? MEM_WAIT : RUN) :
                freeze_pipe ? MEM_WAIT : load_use ? LOAD_USE : RUN;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q    <= '0;
         mem_q   <= '0;
         sel_a_q <= 2'b00;
         sel_b_q <= 2'b00;
         cnt_q   <= '0;
         state_q <= RUN;
      end else begin
         state_q <= state_d;
         if (stall_front && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
         if (!freeze_pipe) begin
            ex_q    <= bubble_ex ? '0 : id_tag;
            mem_q   <= ex_q;
            sel_a_q <= bubble_ex ? 2'b00 : sel_a_d;
            sel_b_q <= bubble_ex ? 2'b00 : sel_b_d;
         end
      end
   end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: instruction-level pipeline model checked every cycle,
// plus literal expectations over per-scenario windows of recorded DUT outputs.
module tb_hazard_stall_controller;
   localparam int AW = 5, CW = 4;
   logic clk = 1'b0, reset = 1'b1;
   logic id_valid = 0, id_rA_used = 0, id_rB_used = 0, id_wr_en = 0, id_is_load = 0, id_is_store = 0;
   logic [AW-1:0] id_rA_address = '0, id_rB_address = '0, id_rD_address = '0;
   logic mem_req_done = 1'b1;
   logic stall_front, bubble_ex, freeze_pipe;
   logic [1:0] fwd_rA_sel, fwd_rB_sel;
   logic [CW-1:0] stall_count;
   always #5 clk = ~clk;
   hazard_stall_controller #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rA_address(id_rA_address),
      .id_rB_address(id_rB_address), .id_rA_used(id_rA_used), .id_rB_used(id_rB_used),
      .id_rD_address(id_rD_address), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
      .id_is_store(id_is_store), .mem_req_done(mem_req_done), .stall_front(stall_front),
      .bubble_ex(bubble_ex), .freeze_pipe(freeze_pipe), .fwd_rA_sel(fwd_rA_sel),
      .fwd_rB_sel(fwd_rB_sel), .stall_count(stall_count));
   typedef struct packed {
      logic v, ua, ub, wr, ld, st;
      logic [AW-1:0] ra, rb, rd;
      logic [7:0] lat;
   } ins_t;
   ins_t cur, ex_m, mem_m, wb_m;
   int cnt_m = 0, checks = 0, failures = 0, cyc = 0;
   logic run = 1'b0;
   int h[1024][6];
   function automatic ins_t mk(logic ua, logic ub, logic wr, logic ld, logic st,
                               int ra, int rb, int rd, int lat);
      ins_t n;
      n = '0;
      n.v = 1'b1; n.ua = ua; n.ub = ub; n.wr = wr; n.ld = ld; n.st = st;
      n.ra = AW'(ra); n.rb = AW'(rb); n.rd = AW'(rd); n.lat = 8'(lat);
      return n;
   endfunction
   function automatic ins_t nop();
      ins_t n;
      n = '0;
      return n;
   endfunction
   function automatic ins_t alu(int rd, int ra, int rb); return mk(1, 1, 1, 0, 0, ra, rb, rd, 0); endfunction
   function automatic ins_t rda(int rd, int ra); return mk(1, 0, 1, 0, 0, ra, 0, rd, 0); endfunction
   function automatic ins_t rdb(int rd, int rb); return mk(0, 1, 1, 0, 0, 0, rb, rd, 0); endfunction
   function automatic ins_t ldi(int rd, int ra, int lat); return mk(1, 0, 1, 1, 0, ra, 0, rd, lat); endfunction
   function automatic ins_t sti(int ra, int rb, int lat); return mk(1, 1, 0, 0, 1, ra, rb, 0, lat); endfunction
   function automatic logic writes(ins_t p, logic [AW-1:0] r); return p.v && p.wr && p.rd == r; endfunction
   function automatic logic m_freeze(); return mem_m.v && (mem_m.ld || mem_m.st) && mem_m.lat != 0; endfunction
   function automatic logic m_lu();
      return cur.v && ex_m.ld && ((cur.ua && writes(ex_m, cur.ra)) || (cur.ub && writes(ex_m, cur.rb)));
   endfunction
   // operand source seen from the consumer's EX cycle: one stage ahead -> EX/MEM, two ahead -> MEM/WB
   function automatic int m_sel(logic used, logic [AW-1:0] r);
      if (!(ex_m.v && used)) return 0;
      return writes(mem_m, r) ? 1 : writes(wb_m, r) ? 2 : 0;
   endfunction
   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
      end
   endtask
   always @(negedge clk) if (run) begin
      chk("stall_front", int'(stall_front), int'(m_freeze() || m_lu()));
      chk("bubble_ex", int'(bubble_ex), int'(m_lu() && !m_freeze()));
      chk("freeze_pipe", int'(freeze_pipe), int'(m_freeze()));
      chk("fwd_rA_sel", int'(fwd_rA_sel), m_sel(ex_m.ua, ex_m.ra));
      chk("fwd_rB_sel", int'(fwd_rB_sel), m_sel(ex_m.ub, ex_m.rb));
      chk("stall_count", int'(stall_count), cnt_m);
      if (cyc < 1024) begin
         h[cyc][0] = int'(stall_front); h[cyc][1] = int'(bubble_ex); h[cyc][2] = int'(freeze_pipe);
         h[cyc][3] = int'(fwd_rA_sel);  h[cyc][4] = int'(fwd_rB_sel); h[cyc][5] = int'(stall_count);
      end
      cyc++;
   end
   function automatic int hcount(int f, int val, int a, int b);
      int n = 0;
      for (int i = a; i < b && i < 1024; i++) if (h[i][f] == val) n++;
      return n;
   endfunction
   task automatic step(input ins_t in, input logic r, output logic acc);
      logic fz, lu;
      cur = in; reset = r;
      id_valid = in.v; id_rA_address = in.ra; id_rB_address = in.rb; id_rD_address = in.rd;
      id_rA_used = in.ua; id_rB_used = in.ub; id_wr_en = in.wr; id_is_load = in.ld; id_is_store = in.st;
      mem_req_done = !m_freeze();
      @(posedge clk);
      fz = m_freeze(); lu = m_lu();
      acc = !(fz || lu);
      if (r) begin
         ex_m = nop(); mem_m = nop(); wb_m = nop(); cnt_m = 0;
      end else begin
         if ((fz || lu) && cnt_m != 2**CW - 1) cnt_m++;
         if (fz) mem_m.lat = mem_m.lat - 8'd1;
         else begin
            wb_m = mem_m; mem_m = ex_m; ex_m = (lu || !in.v) ? nop() : in;
         end
      end
      #1;
   endtask
   task automatic issue(input ins_t in);
      logic acc;
      int n = 0;
      do begin step(in, 1'b0, acc); n++; end while (!acc && n < 40);
      if (!acc) begin checks++; failures++; $display("FAIL issue_timeout cyc=%0d got=stalled exp=accepted", cyc); end
   endtask
   task automatic rst_cycle();
      logic acc;
      step(nop(), 1'b1, acc);
   endtask
   task automatic nops(int n);
      for (int i = 0; i < n; i++) issue(nop());
   endtask
   initial begin
      int w;
      logic acc;
      ex_m = nop(); mem_m = nop(); wb_m = nop(); cur = nop();
      rst_cycle(); rst_cycle();
      run = 1'b1;
      // 1: EX/MEM forward, also for r0
      w = cyc; issue(alu(3, 1, 2)); issue(rda(10, 3)); nops(3);
      chk("t1_fwdA_01", hcount(3, 1, w, cyc), 1); chk("t1_no_stall", hcount(0, 1, w, cyc), 0);
      w = cyc; issue(alu(0, 1, 2)); issue(rda(9, 0)); nops(3);
      chk("t1_r0_fwdA_01", hcount(3, 1, w, cyc), 1);
      // 2: MEM/WB forward, then newest producer wins
      w = cyc; issue(alu(3, 1, 2)); issue(alu(7, 8, 9)); issue(rdb(11, 3)); nops(3);
      chk("t2_fwdB_10", hcount(4, 2, w, cyc), 1); chk("t2_fwdB_no01", hcount(4, 1, w, cyc), 0);
      w = cyc; issue(alu(3, 1, 2)); issue(alu(3, 4, 4)); issue(rdb(12, 3)); nops(3);
      chk("t2_newest_01", hcount(4, 1, w, cyc), 1); chk("t2_newest_no10", hcount(4, 2, w, cyc), 0);
      // 3: load-use, one bubble
      rst_cycle();
      w = cyc; issue(ldi(5, 1, 0)); issue(rda(13, 5)); nops(3);
      chk("t3_bubbles", hcount(1, 1, w, cyc), 1); chk("t3_stalls", hcount(0, 1, w, cyc), 1);
      chk("t3_fwdA_10", hcount(3, 2, w, cyc), 1); chk("t3_count", h[cyc-1][5], 1);
      // 4: memory wait freeze
      rst_cycle();
      w = cyc; issue(ldi(6, 1, 3)); issue(alu(14, 1, 2)); nops(4);
      chk("t4_freezes", hcount(2, 1, w, cyc), 3); chk("t4_bubbles", hcount(1, 1, w, cyc), 0);
      chk("t4_count", h[cyc-1][5], 3);
      rst_cycle();
      w = cyc; issue(sti(3, 4, 2)); issue(rda(9, 3)); nops(4);
      chk("t4_store_freezes", hcount(2, 1, w, cyc), 2); chk("t4_store_nofwd", hcount(3, 0, w, cyc), cyc - w);
      // 5: load-use under a freeze
      rst_cycle();
      w = cyc; issue(ldi(6, 1, 2)); issue(ldi(5, 1, 0)); issue(rda(15, 5)); nops(3);
      chk("t5_freezes", hcount(2, 1, w, cyc), 2); chk("t5_bubbles", hcount(1, 1, w, cyc), 1);
      chk("t5_stalls", hcount(0, 1, w, cyc), 3); chk("t5_fwdA_10", hcount(3, 2, w, cyc), 1);
      // 6: reset mid-freeze and mid-stall
      rst_cycle();
      issue(ldi(6, 1, 5)); step(nop(), 1'b0, acc); step(nop(), 1'b0, acc); step(nop(), 1'b1, acc);
      w = cyc; step(nop(), 1'b0, acc);
      chk("t6_freeze0", h[w][2], 0); chk("t6_stall0", h[w][0], 0); chk("t6_bubble0", h[w][1], 0);
      chk("t6_fwdA0", h[w][3], 0); chk("t6_fwdB0", h[w][4], 0); chk("t6_count0", h[w][5], 0);
      issue(ldi(5, 1, 0)); step(rda(13, 5), 1'b1, acc);
      w = cyc; step(rda(13, 5), 1'b0, acc);
      chk("t6_no_resid_bubble", h[w][1], 0); chk("t6_no_resid_stall", h[w][0], 0);
      nops(2);
      // saturation: 23 stall cycles into a 4-bit counter
      rst_cycle();
      issue(ldi(6, 1, 10)); issue(ldi(7, 1, 10)); nops(3); issue(ldi(8, 1, 3)); nops(4);
      chk("sat_count", h[cyc-1][5], 15);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
